// File: rtl/dmem_pkg.sv
// Shared definitions for the data memory unit: access-size encodings, FSM states
// and the natural-alignment check.
package dmem_pkg;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // An access of 2^size bytes is aligned when the low size address bits are zero.
  function automatic logic is_aligned(input logic [2:0] addr_lo, input logic [1:0] size);
    case (size)
      SZ_B:    is_aligned = 1'b1;
      SZ_H:    is_aligned = (addr_lo[0] == 1'b0);
      SZ_W:    is_aligned = (addr_lo[1:0] == 2'b00);
      default: is_aligned = (addr_lo == 3'b000);
    endcase
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane steering: store byte-enables and shifted store data,
// plus load byte extraction with sign or zero extension.
module dmem_lane_align
  import dmem_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [2:0]          i_lane,
  input  logic [1:0]          i_size,
  input  logic                i_unsigned,
  input  logic [DATA_W-1:0]   i_wdata,
  input  logic [DATA_W-1:0]   i_rword,
  output logic [DATA_W/8-1:0] o_be,
  output logic [DATA_W-1:0]   o_wdata,
  output logic [DATA_W-1:0]   o_rdata
);

  localparam int NB = DATA_W / 8;

  int                w_lane;
  int                w_nbytes;
  int                w_nbits;
  logic [DATA_W-1:0] w_shifted;
  logic              w_sign;

  always_comb begin
    w_lane    = int'(i_lane);
    w_nbytes  = 1 << i_size;
    w_nbits   = (8 * w_nbytes > DATA_W) ? DATA_W : 8 * w_nbytes;
    w_shifted = i_rword >> (8 * w_lane);
    w_sign    = w_shifted[DATA_W-1];
    case (i_size)
      SZ_B:    w_sign = w_shifted[7];
      SZ_H:    w_sign = w_shifted[15];
      SZ_W:    w_sign = w_shifted[31];
      default: w_sign = w_shifted[DATA_W-1];
    endcase

    o_be = '0;
    for (int b = 0; b < NB; b++) begin
      o_be[b] = (b >= w_lane) && (b < w_lane + w_nbytes);
    end
    o_wdata = i_wdata << (8 * w_lane);

    // Bits above the access width replicate the sign bit unless zero-extending.
    o_rdata = '0;
    for (int i = 0; i < DATA_W; i++) begin
      o_rdata[i] = (i < w_nbits) ? w_shifted[i] : (w_sign && !i_unsigned);
    end
  end

endmodule

// File: rtl/dmem_unit.sv
// Byte-addressed data memory for the MEM stage with valid/ready handshake and a post-reset clear.
// Define DMEM_TRACE_EN to print one simulation line per accepted request.
module dmem_unit
  import dmem_pkg::*;
#(
  parameter int DATA_W         = 32,
  parameter int DEPTH          = 1024,
  parameter int ADDR_W         = 32,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_write,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic [1:0]        i_req_size,
  input  logic              i_req_unsigned,
  input  logic [DATA_W-1:0] i_req_wdata,
  output logic              o_rsp_valid,
  input  logic              i_rsp_ready,
  output logic [DATA_W-1:0] o_rsp_rdata,
  output logic              o_rsp_err,
  output logic              o_init_busy
);

  localparam int NB    = DATA_W / 8;
  localparam int OFF_W = $clog2(NB);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] r_mem [DEPTH];
  state_e            r_state;
  state_e            w_state_nxt;
  logic [IDX_W-1:0]  r_clr_cnt;
  logic              r_rsp_valid;
  logic              r_rsp_err;
  logic [DATA_W-1:0] r_rsp_rdata;

  logic [ADDR_W-1:0] w_word;
  logic [IDX_W-1:0]  w_idx;
  logic              w_misal;
  logic              w_oob;
  logic              w_err;
  logic              w_accept;
  logic              w_st_we;
  logic              w_clr_we;
  logic [NB-1:0]     w_be;
  logic [DATA_W-1:0] w_wdata_sh;
  logic [DATA_W-1:0] w_rword;
  logic [DATA_W-1:0] w_load;

  assign w_word   = i_req_addr >> OFF_W;
  assign w_idx    = w_word[IDX_W-1:0];
  assign w_misal  = ((DATA_W == 32) && (i_req_size == SZ_D)) ||
                    !is_aligned(i_req_addr[2:0], i_req_size);
  assign w_oob    = (w_word >= ADDR_W'(DEPTH));
  assign w_err    = w_misal || w_oob;
  assign w_accept = i_req_valid && o_req_ready;
  assign w_st_we  = w_accept && i_req_write && !w_err;
  assign w_rword  = r_mem[w_idx];

  assign o_init_busy = (r_state == ST_INIT);
  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_rdata = r_rsp_rdata;
  assign o_rsp_err   = r_rsp_err;

  dmem_lane_align #(.DATA_W(DATA_W)) u_lane (
    .i_lane     (3'(i_req_addr[OFF_W-1:0])),
    .i_size     (i_req_size),
    .i_unsigned (i_req_unsigned),
    .i_wdata    (i_req_wdata),
    .i_rword    (w_rword),
    .o_be       (w_be),
    .o_wdata    (w_wdata_sh),
    .o_rdata    (w_load)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= ST_INIT;
      r_clr_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_INIT) r_clr_cnt <= r_clr_cnt + 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_clr_we    = 1'b0;
    o_req_ready = 1'b0;
    case (r_state)
      ST_INIT: begin
        w_clr_we = (CLEAR_ON_RESET != 0);
        if ((CLEAR_ON_RESET == 0) || (r_clr_cnt == IDX_W'(DEPTH - 1))) w_state_nxt = ST_RUN;
      end
      ST_RUN:  o_req_ready = !r_rsp_valid || i_rsp_ready;
      default: w_state_nxt = ST_INIT;
    endcase
  end

  // Storage carries no reset; the INIT sequence is what zeroes it.
  always_ff @(posedge i_clk) begin
    if (w_clr_we) begin
      r_mem[r_clr_cnt] <= '0;
    end else if (w_st_we) begin
      for (int b = 0; b < NB; b++) begin
        if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wdata_sh[8*b +: 8];
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= '0;
    end else if (w_accept) begin
      r_rsp_valid <= 1'b1;
      r_rsp_err   <= w_err;
      r_rsp_rdata <= (i_req_write || w_err) ? '0 : w_load;
    end else if (i_rsp_ready) begin
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= '0;
    end
  end

`ifdef DMEM_TRACE_EN
  always @(posedge i_clk) begin
    if (w_accept)
      $display("[dmem] t=%0t %s addr=0x%h size=%0d data=0x%h err=%0b", $time,
               i_req_write ? "W" : "R", i_req_addr, i_req_size,
               i_req_write ? i_req_wdata : (w_err ? '0 : w_load), w_err);
  end
`else
`endif

endmodule

// File: tb/tb_dmem_unit.sv
// Directed scoreboard bench for dmem_unit (DATA_W=32, DEPTH=16, clear on reset).
module tb_dmem_unit;
  import dmem_pkg::*;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic        clk;
  logic        rstN;
  logic        reqValid;
  logic        reqReady;
  logic        reqWrite;
  logic [31:0] reqAddr;
  logic [1:0]  reqSize;
  logic        reqUnsigned;
  logic [31:0] reqWdata;
  logic        rspValid;
  logic        rspReady;
  logic [31:0] rspRdata;
  logic        rspErr;
  logic        initBusy;

  exp_t expQ[$];
  int   checks = 0;
  int   errors = 0;
  int   waited;
  int   cycles;

  dmem_unit #(.DATA_W(32), .DEPTH(16), .ADDR_W(32), .CLEAR_ON_RESET(1)) dut (
    .i_clk          (clk),
    .i_rst_n        (rstN),
    .i_req_valid    (reqValid),
    .o_req_ready    (reqReady),
    .i_req_write    (reqWrite),
    .i_req_addr     (reqAddr),
    .i_req_size     (reqSize),
    .i_req_unsigned (reqUnsigned),
    .i_req_wdata    (reqWdata),
    .o_rsp_valid    (rspValid),
    .i_rsp_ready    (rspReady),
    .o_rsp_rdata    (rspRdata),
    .o_rsp_err      (rspErr),
    .o_init_busy    (initBusy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Pushes the expected response, drives the request and returns 1 ns after the accept edge.
  task automatic applyStimulus(input logic wr, input logic [31:0] addr, input logic [1:0] sz,
                               input logic uns, input logic [31:0] wd,
                               input logic [31:0] expData, input logic expErr,
                               output int nWait);
    expQ.push_back('{rdata: expData, err: expErr});
    reqWrite    = wr;
    reqAddr     = addr;
    reqSize     = sz;
    reqUnsigned = uns;
    reqWdata    = wd;
    reqValid    = 1'b1;
    nWait = 0;
    while (!reqReady && nWait < 100) begin
      @(negedge clk);
      nWait++;
    end
    check("accept_ready", {31'b0, reqReady}, 32'd1);
    @(posedge clk);
    #1;
    reqValid = 1'b0;
  endtask

  task automatic checkOutput(input string tag);
    exp_t e;
    checks++;
    assert (expQ.size() != 0)
    else begin
      errors++;
      $error("[TB] FAIL %s_sb: observed empty queue expected an entry", tag);
    end
    if (expQ.size() != 0) begin
      e = expQ.pop_front();
      check({tag, "_valid"}, {31'b0, rspValid}, 32'd1);
      check({tag, "_rdata"}, rspRdata, e.rdata);
      check({tag, "_err"}, {31'b0, rspErr}, {31'b0, e.err});
    end
  endtask

  task automatic idleCycle();
    reqValid = 1'b0;
    rspReady = 1'b1;
    @(negedge clk);
    @(negedge clk);
  endtask

  initial begin
    rstN = 1'b0; reqValid = 1'b0; reqWrite = 1'b0; reqAddr = '0;
    reqSize = SZ_W; reqUnsigned = 1'b1; reqWdata = '0; rspReady = 1'b1;

    #3;
    check("rst_req_ready", {31'b0, reqReady}, 32'd0);
    check("rst_rsp_valid", {31'b0, rspValid}, 32'd0);
    check("rst_rsp_rdata", rspRdata, 32'd0);
    check("rst_rsp_err", {31'b0, rspErr}, 32'd0);
    check("rst_init_busy", {31'b0, initBusy}, 32'd1);

    @(negedge clk);
    @(negedge clk);
    rstN = 1'b1;
    cycles = 0;
    while (initBusy && cycles < 100) begin
      @(posedge clk);
      #1;
      cycles++;
    end
    check("init_cycles", 32'(cycles), 32'd16);

    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b0, 32'(i * 4), SZ_W, 1'b1, 32'h0, 32'h0, 1'b0, waited);
      checkOutput("clear_load");
    end

    applyStimulus(1'b1, 32'h20, SZ_W, 1'b0, 32'hCAFEBABE, 32'h0, 1'b0, waited);
    checkOutput("st_word");
    applyStimulus(1'b0, 32'h23, SZ_B, 1'b1, 32'h0, 32'h000000CA, 1'b0, waited);
    checkOutput("ld_byte_u");
    applyStimulus(1'b0, 32'h23, SZ_B, 1'b0, 32'h0, 32'hFFFFFFCA, 1'b0, waited);
    checkOutput("ld_byte_s");
    applyStimulus(1'b0, 32'h20, SZ_H, 1'b0, 32'h0, 32'hFFFFBABE, 1'b0, waited);
    checkOutput("ld_half_s");
    applyStimulus(1'b0, 32'h20, SZ_B, 1'b1, 32'h0, 32'h000000BE, 1'b0, waited);
    checkOutput("ld_byte0_u");

    applyStimulus(1'b1, 32'h22, SZ_H, 1'b0, 32'hFFFF1234, 32'h0, 1'b0, waited);
    checkOutput("st_half");
    applyStimulus(1'b0, 32'h20, SZ_W, 1'b1, 32'h0, 32'h1234BABE, 1'b0, waited);
    checkOutput("ld_after_half");
    applyStimulus(1'b1, 32'h21, SZ_B, 1'b0, 32'h0000005A, 32'h0, 1'b0, waited);
    checkOutput("st_byte");
    applyStimulus(1'b0, 32'h20, SZ_W, 1'b1, 32'h0, 32'h12345ABE, 1'b0, waited);
    checkOutput("ld_after_byte");

    applyStimulus(1'b0, 32'h21, SZ_W, 1'b1, 32'h0, 32'h0, 1'b1, waited);
    checkOutput("err_misal_ld");
    applyStimulus(1'b1, 32'h21, SZ_W, 1'b0, 32'hDEADBEEF, 32'h0, 1'b1, waited);
    checkOutput("err_misal_st");
    applyStimulus(1'b0, 32'h40, SZ_W, 1'b1, 32'h0, 32'h0, 1'b1, waited);
    checkOutput("err_oob_ld");
    applyStimulus(1'b1, 32'h40, SZ_W, 1'b0, 32'hDEADBEEF, 32'h0, 1'b1, waited);
    checkOutput("err_oob_st");
    applyStimulus(1'b0, 32'h20, SZ_D, 1'b1, 32'h0, 32'h0, 1'b1, waited);
    checkOutput("err_dword");
    applyStimulus(1'b0, 32'h23, SZ_H, 1'b1, 32'h0, 32'h0, 1'b1, waited);
    checkOutput("err_half");
    applyStimulus(1'b0, 32'h20, SZ_W, 1'b1, 32'h0, 32'h12345ABE, 1'b0, waited);
    checkOutput("err_no_update");

    idleCycle();
    rspReady = 1'b0;
    reqWrite = 1'b0; reqAddr = 32'h20; reqSize = SZ_W; reqUnsigned = 1'b1; reqValid = 1'b1;
    expQ.push_back('{rdata: 32'h12345ABE, err: 1'b0});
    check("stall_ready_idle", {31'b0, reqReady}, 32'd1);
    @(posedge clk);
    #1;
    reqAddr = 32'h23; reqSize = SZ_B;
    expQ.push_back('{rdata: 32'h00000012, err: 1'b0});
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("stall_ready", {31'b0, reqReady}, 32'd0);
      check("stall_valid", {31'b0, rspValid}, 32'd1);
      check("stall_rdata", rspRdata, 32'h12345ABE);
    end
    rspReady = 1'b1;
    #1;
    check("stall_release_ready", {31'b0, reqReady}, 32'd1);
    checkOutput("stall_rsp");
    @(posedge clk);
    #1;
    reqValid = 1'b0;
    checkOutput("b2b_first");
    applyStimulus(1'b1, 32'h24, SZ_W, 1'b0, 32'hA5A5A5A5, 32'h0, 1'b0, waited);
    check("b2b_bubble_st", 32'(waited), 32'd0);
    checkOutput("b2b_st");
    applyStimulus(1'b0, 32'h24, SZ_W, 1'b1, 32'h0, 32'hA5A5A5A5, 1'b0, waited);
    check("b2b_bubble_raw", 32'(waited), 32'd0);
    checkOutput("b2b_raw");
    applyStimulus(1'b0, 32'h26, SZ_H, 1'b0, 32'h0, 32'hFFFFA5A5, 1'b0, waited);
    check("b2b_bubble_half", 32'(waited), 32'd0);
    checkOutput("b2b_half");

    idleCycle();
    rspReady = 1'b0;
    applyStimulus(1'b0, 32'h20, SZ_W, 1'b1, 32'h0, 32'h12345ABE, 1'b0, waited);
    checkOutput("pre_reset");
    #2;
    rstN = 1'b0;
    #1;
    check("midrst_valid", {31'b0, rspValid}, 32'd0);
    check("midrst_rdata", rspRdata, 32'd0);
    check("midrst_busy", {31'b0, initBusy}, 32'd1);
    check("midrst_ready", {31'b0, reqReady}, 32'd0);
    @(negedge clk);
    rstN = 1'b1;
    rspReady = 1'b1;
    applyStimulus(1'b0, 32'h20, SZ_W, 1'b1, 32'h0, 32'h0, 1'b0, waited);
    check("reclear_wait", 32'(waited), 32'd16);
    checkOutput("reclear_w8");
    applyStimulus(1'b0, 32'h24, SZ_W, 1'b1, 32'h0, 32'h0, 1'b0, waited);
    checkOutput("reclear_w9");

    check("sb_empty", 32'(expQ.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
